// File: rtl/cache_arbiter_pkg.sv
// Shared types for the icache/dcache memory arbiter: FSM states, grant
// owner encoding and the line/address widths used on every port.
package cache_arbiter_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } grant_e;

    // Tie-break between simultaneous requesters. Fair mode alternates away
    // from the previous winner; unfair mode always favours the dcache.
    function automatic grant_e tie_winner(input logic fair, input grant_e last);
        grant_e win;
        win = DCACHE;
        if (fair) begin
            win = (last == ICACHE) ? DCACHE : ICACHE;
        end
        return win;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Two-port arbiter that funnels icache line fills and dcache fills or
// writebacks onto the single cacheline adaptor port. One transaction is
// in flight at a time; the winner's address, op and wdata are latched on
// the grant edge so the mem_* side never sees the requester inputs directly.
//
// Handshake: a requester raises *_read / *_write with a stable address (and
// wdata) and holds it until its *_resp strobe, which is high for exactly one
// cycle together with valid *_rdata. Downstream, mem_read / mem_write stay
// high from the cycle after the grant until the cycle mem_resp is seen; the
// adaptor returns mem_rdata in that same mem_resp cycle.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,

    output arb_state_e        dbg_state_o
);

    arb_state_e        state_q,      state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [LINE_W-1:0] wdata_q,      wdata_d;
    logic              write_q,      write_d;
    logic [LINE_W-1:0] i_rdata_q,    i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q,    d_rdata_d;

    logic              i_req;
    logic              d_req;
    grant_e            grant;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Next-state, grant latching and output decode for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant        = ICACHE;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    grant = tie_winner(FAIR, last_grant_q);
                end else if (d_req) begin
                    grant = DCACHE;
                end else begin
                    grant = ICACHE;
                end

                if (i_req || d_req) begin
                    last_grant_d = grant;
                    if (grant == DCACHE) begin
                        state_d = D_BUSY;
                        addr_d  = d_pmem_address;
                        wdata_d = d_pmem_wdata;
                        // A writeback always beats a fill if both are raised.
                        write_d = d_pmem_write;
                    end else begin
                        state_d = I_BUSY;
                        addr_d  = i_pmem_address;
                        wdata_d = '0;
                        write_d = 1'b0;
                    end
                end
            end

            I_BUSY: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    i_pmem_resp = 1'b1;
                    i_rdata_d   = mem_rdata;
                    state_d     = DONE;
                end
            end

            D_BUSY: begin
                mem_read  = ~write_q;
                mem_write = write_q;
                if (mem_resp) begin
                    d_pmem_resp = 1'b1;
                    d_rdata_d   = mem_rdata;
                    state_d     = DONE;
                end
            end

            // One dead cycle lets the served cache drop its request before
            // the next arbitration, so a lingering request is not regranted.
            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // An aborted transaction must never complete toward the caches.
        if (rst) begin
            i_pmem_resp = 1'b0;
            d_pmem_resp = 1'b0;
        end
    end

    // Returned lines pass straight through on the resp cycle, then hold.
    always_comb begin
        i_pmem_rdata = i_pmem_resp ? mem_rdata : i_rdata_q;
        d_pmem_rdata = d_pmem_resp ? mem_rdata : d_rdata_q;
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign dbg_state_o = state_q;

    // State and latched-transaction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ICACHE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter. Two instances share all inputs: u_fair
// (FAIR=1) and u_nf (FAIR=0). Both always grant when anything is pending,
// so their BUSY/DONE timing stays in lockstep and one adaptor model serves
// both. Inputs change on the falling edge; outputs are sampled shortly after.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- shared inputs ----------------
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    // ---------------- outputs: FAIR=1 ----------------
    logic [LINE_W-1:0] f_i_rdata, f_d_rdata, f_mem_wdata;
    logic              f_i_resp, f_d_resp, f_mem_read, f_mem_write;
    logic [ADDR_W-1:0] f_mem_address;
    arb_state_e        f_state;

    // ---------------- outputs: FAIR=0 ----------------
    logic [LINE_W-1:0] n_i_rdata, n_d_rdata, n_mem_wdata;
    logic              n_i_resp, n_d_resp, n_mem_read, n_mem_write;
    logic [ADDR_W-1:0] n_mem_address;
    arb_state_e        n_state;

    cache_arbiter #(.FAIR(1'b1)) u_fair (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(f_i_rdata), .i_pmem_resp(f_i_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(f_d_rdata), .d_pmem_resp(f_d_resp),
        .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_address(f_mem_address), .mem_wdata(f_mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .dbg_state_o(f_state)
    );

    cache_arbiter #(.FAIR(1'b0)) u_nf (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(n_i_rdata), .i_pmem_resp(n_i_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(n_d_rdata), .d_pmem_resp(n_d_resp),
        .mem_read(n_mem_read), .mem_write(n_mem_write),
        .mem_address(n_mem_address), .mem_wdata(n_mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .dbg_state_o(n_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit mon_on   = 1'b0;

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] obs,
                            input logic [LINE_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        mem_rdata      = '0;
        mem_resp       = 1'b0;
    endtask

    // ---------------- per-cycle invariants ----------------
    logic pf_i, pf_d, pn_i, pn_d;
    initial begin
        pf_i = 1'b0; pf_d = 1'b0; pn_i = 1'b0; pn_d = 1'b0;
    end

    always @(negedge clk) begin
        #2;
        if (mon_on) begin
            check_eq("f_rw_excl", f_mem_read & f_mem_write, 0);
            check_eq("n_rw_excl", n_mem_read & n_mem_write, 0);
            check_eq("f_i_pulse", pf_i & f_i_resp, 0);
            check_eq("f_d_pulse", pf_d & f_d_resp, 0);
            check_eq("n_i_pulse", pn_i & n_i_resp, 0);
            check_eq("n_d_pulse", pn_d & n_d_resp, 0);
            check_eq("f_ign", ((f_state == IDLE) || (f_state == DONE)) & (f_i_resp | f_d_resp), 0);
            check_eq("n_ign", ((n_state == IDLE) || (n_state == DONE)) & (n_i_resp | n_d_resp), 0);
        end
        pf_i = f_i_resp; pf_d = f_d_resp; pn_i = n_i_resp; pn_d = n_d_resp;
    end

    // ---------------- directed vectors ----------------
    localparam logic [LINE_W-1:0] LINE_A5 = {8{32'hA5A5_A5A5}};
    localparam logic [LINE_W-1:0] LINE_WB = {8{32'h0BAD_F00D}};
    localparam logic [LINE_W-1:0] LINE_R1 = {8{32'h1111_1111}};
    localparam logic [LINE_W-1:0] LINE_R2 = {8{32'h2222_2222}};
    localparam logic [LINE_W-1:0] LINE_R4 = {8{32'h4444_4444}};
    localparam logic [LINE_W-1:0] LINE_R5 = {8{32'h5555_5555}};
    localparam logic [LINE_W-1:0] WDATA_2 = {8{32'hCAFE_0002}};

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;

        // Reset state
        check_eq("rst_state", f_state, IDLE);
        check_eq("rst_mem_read", f_mem_read, 0);
        check_eq("rst_mem_write", f_mem_write, 0);
        check_eq("rst_mem_addr", f_mem_address, 0);
        check_eq("rst_mem_wdata", f_mem_wdata, 0);
        check_eq("rst_i_resp", f_i_resp, 0);
        check_eq("rst_d_resp", f_d_resp, 0);
        check_eq("rst_i_rdata", f_i_rdata, 0);
        check_eq("rst_d_rdata", f_d_rdata, 0);
        check_eq("rst_nf_state", n_state, IDLE);
        mon_on = 1'b1;

        // I-only fill, adaptor answers on the fifth busy cycle
        step(); i_pmem_read = 1'b1; i_pmem_address = 32'h60; #1;
        check_eq("ionly_no_comb", f_mem_read, 0);
        step(); #1;
        check_eq("ionly_state", f_state, I_BUSY);
        check_eq("ionly_mem_read", f_mem_read, 1);
        check_eq("ionly_mem_write", f_mem_write, 0);
        check_eq("ionly_addr", f_mem_address, 32'h60);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            check_eq("ionly_wait_resp", f_i_resp, 0);
        end
        step(); mem_resp = 1'b1; mem_rdata = LINE_A5; #1;
        check_eq("ionly_i_resp", f_i_resp, 1);
        check_eq("ionly_i_rdata", f_i_rdata, LINE_A5);
        check_eq("ionly_d_resp", f_d_resp, 0);
        check_eq("ionly_d_rdata", f_d_rdata, 0);
        // request lingers through DONE; it must not be regranted
        step(); mem_resp = 1'b0; mem_rdata = {8{32'hDEAD_BEEF}}; #1;
        check_eq("ionly_done", f_state, DONE);
        check_eq("ionly_done_mem", f_mem_read, 0);
        check_eq("ionly_rdata_hold", f_i_rdata, LINE_A5);
        step(); i_pmem_read = 1'b0; #1;
        check_eq("ionly_stale_idle", f_state, IDLE);
        check_eq("ionly_stale_mem", f_mem_read, 0);

        // mem_resp in IDLE is ignored
        step(); mem_resp = 1'b1; mem_rdata = {8{32'h7777_7777}}; #1;
        check_eq("ign_i_resp", f_i_resp, 0);
        check_eq("ign_d_resp", f_d_resp, 0);
        check_eq("ign_i_rdata", f_i_rdata, LINE_A5);
        step(); mem_resp = 1'b0; #1;
        check_eq("ign_state", f_state, IDLE);

        // D writeback
        step(); d_pmem_write = 1'b1; d_pmem_address = 32'h80; d_pmem_wdata = 256'h1234; #1;
        step(); #1;
        check_eq("dwb_state", f_state, D_BUSY);
        check_eq("dwb_mem_write", f_mem_write, 1);
        check_eq("dwb_mem_read", f_mem_read, 0);
        check_eq("dwb_addr", f_mem_address, 32'h80);
        check_eq("dwb_wdata", f_mem_wdata, 256'h1234);
        step(); #1;
        step(); mem_resp = 1'b1; mem_rdata = LINE_WB; #1;
        check_eq("dwb_d_resp", f_d_resp, 1);
        check_eq("dwb_i_resp", f_i_resp, 0);
        check_eq("dwb_i_rdata_hold", f_i_rdata, LINE_A5);
        step(); mem_resp = 1'b0; d_pmem_write = 1'b0; #1;
        check_eq("dwb_done", f_state, DONE);
        step(); #1;
        check_eq("dwb_idle", f_state, IDLE);

        // Tie with last grant = dcache: fair picks icache, unfair picks dcache
        step(); i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h200; #1;
        step(); #1;
        check_eq("tie1_f_state", f_state, I_BUSY);
        check_eq("tie1_f_addr", f_mem_address, 32'h100);
        check_eq("tie1_n_state", n_state, D_BUSY);
        check_eq("tie1_n_addr", n_mem_address, 32'h200);
        step(); mem_resp = 1'b1; mem_rdata = LINE_R1; #1;
        check_eq("tie1_f_i_resp", f_i_resp, 1);
        check_eq("tie1_f_d_resp", f_d_resp, 0);
        check_eq("tie1_f_d_hold", f_d_rdata, LINE_WB);
        step(); mem_resp = 1'b0; i_pmem_read = 1'b0; #1;
        check_eq("tie1_f_done", f_state, DONE);
        step(); #1;
        check_eq("tie1_f_idle", f_state, IDLE);
        step(); #1;
        check_eq("tie1_f_dgrant", f_state, D_BUSY);
        check_eq("tie1_f_daddr", f_mem_address, 32'h200);
        check_eq("tie1_f_dread", f_mem_read, 1);
        step(); mem_resp = 1'b1; mem_rdata = LINE_R2; #1;
        check_eq("tie1_f_d_resp2", f_d_resp, 1);
        check_eq("tie1_f_d_rdata", f_d_rdata, LINE_R2);
        check_eq("tie1_f_i_hold", f_i_rdata, LINE_R1);
        step(); mem_resp = 1'b0; d_pmem_read = 1'b0; #1;
        step(); #1;

        // Write beats read when both are raised
        step(); d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        d_pmem_address = 32'hA0; d_pmem_wdata = WDATA_2; #1;
        step(); #1;
        check_eq("prec_mem_write", f_mem_write, 1);
        check_eq("prec_mem_read", f_mem_read, 0);
        check_eq("prec_wdata", f_mem_wdata, WDATA_2);
        step(); mem_resp = 1'b1; #1;
        check_eq("prec_d_resp", f_d_resp, 1);
        step(); mem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; #1;
        step(); #1;

        // Reset during D_BUSY aborts without a resp
        step(); d_pmem_read = 1'b1; d_pmem_address = 32'h300; #1;
        step(); #1;
        check_eq("rbusy_state", f_state, D_BUSY);
        step(); rst = 1'b1; mem_resp = 1'b1; mem_rdata = {8{32'h3333_3333}}; #1;
        check_eq("rbusy_f_d_resp", f_d_resp, 0);
        check_eq("rbusy_f_i_resp", f_i_resp, 0);
        check_eq("rbusy_n_d_resp", n_d_resp, 0);
        step(); rst = 1'b0; mem_resp = 1'b0; d_pmem_read = 1'b0; #1;
        check_eq("rbusy_idle", f_state, IDLE);
        check_eq("rbusy_mem_read", f_mem_read, 0);
        check_eq("rbusy_mem_write", f_mem_write, 0);
        check_eq("rbusy_addr", f_mem_address, 0);
        check_eq("rbusy_wdata", f_mem_wdata, 0);
        check_eq("rbusy_d_rdata", f_d_rdata, 0);

        // Tie right after reset: dcache first, then icache after one DONE cycle
        step(); i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h200; #1;
        step(); #1;
        check_eq("tie0_state", f_state, D_BUSY);
        check_eq("tie0_addr", f_mem_address, 32'h200);
        step(); mem_resp = 1'b1; mem_rdata = LINE_R4; #1;
        check_eq("tie0_d_resp", f_d_resp, 1);
        check_eq("tie0_i_resp", f_i_resp, 0);
        step(); mem_resp = 1'b0; d_pmem_read = 1'b0; #1;
        check_eq("tie0_done", f_state, DONE);
        step(); #1;
        check_eq("tie0_idle", f_state, IDLE);
        check_eq("tie0_idle_mem", f_mem_read, 0);
        step(); #1;
        check_eq("tie0_igrant", f_state, I_BUSY);
        check_eq("tie0_iaddr", f_mem_address, 32'h100);
        step(); mem_resp = 1'b1; mem_rdata = LINE_R5; #1;
        check_eq("tie0_i_resp", f_i_resp, 1);
        check_eq("tie0_i_rdata", f_i_rdata, LINE_R5);
        step(); mem_resp = 1'b0; i_pmem_read = 1'b0; #1;
        step(); #1;
        step(); #1;

        // FAIR=0: dcache keeps re-requesting and wins every round
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        step(); i_pmem_read = 1'b1; i_pmem_address = 32'h400;
        d_pmem_read = 1'b1; d_pmem_address = 32'h500; #1;
        for (int k = 0; k < 3; k++) begin
            logic [ADDR_W-1:0] exp_addr;
            exp_addr = 32'h500 + 32'(k) * 32'h20;
            step(); #1;
            check_eq("nf_state", n_state, D_BUSY);
            check_eq("nf_addr", n_mem_address, exp_addr);
            step(); mem_resp = 1'b1; mem_rdata = {8{32'(k) + 32'h9000}}; #1;
            check_eq("nf_d_resp", n_d_resp, 1);
            check_eq("nf_i_resp", n_i_resp, 0);
            check_eq("nf_d_rdata", n_d_rdata, {8{32'(k) + 32'h9000}});
            step(); mem_resp = 1'b0; d_pmem_address = exp_addr + 32'h20;
            if (k == 2) d_pmem_read = 1'b0;
            #1;
            check_eq("nf_done", n_state, DONE);
            step(); #1;
            check_eq("nf_idle", n_state, IDLE);
        end
        step(); #1;
        check_eq("nf_i_finally", n_state, I_BUSY);
        check_eq("nf_i_addr", n_mem_address, 32'h400);
        step(); mem_resp = 1'b1; mem_rdata = LINE_A5; #1;
        check_eq("nf_i_resp_final", n_i_resp, 1);
        step(); mem_resp = 1'b0; i_pmem_read = 1'b0; #1;
        step(); #1;
        step(); #1;

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
